// File: rtl/cache_pkg.sv
// Shared constants and types for the cache refill arbiter.
package cache_pkg;

  // Cache line geometry: 128-bit line, 16 bytes, 4 offset bits.
  localparam int LINE_W = 128;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  // Requester port indices.
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector: a lone request wins outright,
// and on a tie the port that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the round-robin pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one line-fill memory port between the instruction cache (port 0)
// and the data cache (port 1). One miss is in flight at a time; the line
// comes back through a shared register and is pulsed to the winner only.
//
// Handshake contract: rd_reqN is held high (address stable) until that
// port sees its one-cycle ret_validN. mem_rd_req is held high until the
// one-cycle mem_ret_valid; mem_ret_valid outside BUSY is ignored.
module cache_refill_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = cache_pkg::LINE_W,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req0,
  input  logic [ADDR_W-1:0]       rd_addr0,
  input  logic                    rd_req1,
  input  logic [ADDR_W-1:0]       rd_addr1,
  output logic                    ret_valid0,
  output logic [LINE_W-1:0]       ret_data0,
  output logic                    ret_valid1,
  output logic [LINE_W-1:0]       ret_data1,
  output logic                    mem_rd_req,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic                    mem_ret_valid,
  input  logic [LINE_W-1:0]       mem_ret_data,
  output logic [1:0]              gnt,
  output logic                    timeout_err,
  output cache_pkg::arb_state_e   state_dbg
);

  import cache_pkg::*;

  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 1);

  arb_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [1:0]        gnt_q;
  logic [1:0]        mask_q;
  logic              last_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] addr_sel;

  // The just-served port is hidden for one IDLE cycle so a cache that drops
  // its request a cycle after ret_valid is not served twice.
  rr_pick2 u_pick (
    .req  ({rd_req1, rd_req0} & ~mask_q),
    .last (last_q),
    .gnt  (pick)
  );

  assign addr_sel    = pick[PORT_D] ? rd_addr1 : rd_addr0;
  assign mem_rd_addr = addr_q;
  assign ret_data0   = line_q;
  assign ret_data1   = line_q;
  assign gnt         = gnt_q;
  assign state_dbg   = state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nxt  = state;
    mem_rd_req = 1'b0;
    ret_valid0 = 1'b0;
    ret_valid1 = 1'b0;
    case (state)
      ARB_IDLE: if (|pick) state_nxt = ARB_BUSY;
      ARB_BUSY: begin
        mem_rd_req = 1'b1;
        if (mem_ret_valid) state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        ret_valid0 = gnt_q[PORT_I];
        ret_valid1 = gnt_q[PORT_D];
        state_nxt  = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Grant latch, line register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      line_q      <= '0;
      gnt_q       <= 2'b00;
      mask_q      <= 2'b00;
      last_q      <= 1'b1;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      mask_q <= 2'b00;
      case (state)
        ARB_IDLE: begin
          if (|pick) begin
            addr_q <= addr_sel & ALIGN_MASK;
            gnt_q  <= pick;
            last_q <= pick[PORT_D];
          end
        end
        ARB_BUSY: begin
          if (mem_ret_valid) begin
            line_q <= mem_ret_data;
          end else begin
            if (wait_cnt != CNT_SAT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (TIMEOUT != 0 && wait_cnt == CNT_TRIP) timeout_err <= 1'b1;
          end
        end
        ARB_RESP: begin
          gnt_q    <= 2'b00;
          wait_cnt <= '0;
          mask_q   <= gnt_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: single miss, tie-break and
// back-to-back service, fairness, zero-wait memory, timeout and reset.
module tb_cache_refill_arbiter;
  import cache_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LW     = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req0, rd_req1;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1;
  logic              ret_valid0, ret_valid1;
  logic [LW-1:0]     ret_data0, ret_data1;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_ret_valid;
  logic [LW-1:0]     mem_ret_data;
  logic [1:0]        gnt;
  logic              timeout_err;
  arb_state_e        state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [LW-1:0] LINE_A = 128'h34567891_02345678_91023456_78910234;
  localparam logic [LW-1:0] LINE_B = 128'hCAFE0000_11112222_33334444_55556666;

  cache_refill_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LW), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req0       (rd_req0),
    .rd_addr0      (rd_addr0),
    .rd_req1       (rd_req1),
    .rd_addr1      (rd_addr1),
    .ret_valid0    (ret_valid0),
    .ret_data0     (ret_data0),
    .ret_valid1    (ret_valid1),
    .ret_data1     (ret_data1),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_ret_valid (mem_ret_valid),
    .mem_ret_data  (mem_ret_data),
    .gnt           (gnt),
    .timeout_err   (timeout_err),
    .state_dbg     (state_dbg)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    LW'(state_dbg),   LW'(ARB_IDLE));
    check({tag, "_memreq"},   LW'(mem_rd_req),  '0);
    check({tag, "_memaddr"},  LW'(mem_rd_addr), '0);
    check({tag, "_rv0"},      LW'(ret_valid0),  '0);
    check({tag, "_rv1"},      LW'(ret_valid1),  '0);
    check({tag, "_gnt"},      LW'(gnt),         '0);
    check({tag, "_timeout"},  LW'(timeout_err), '0);
    check({tag, "_line"},     ret_data0,        '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_req0 = 1'b0; rd_req1 = 1'b0;
    rd_addr0 = '0; rd_addr1 = '0;
    mem_ret_valid = 1'b0; mem_ret_data = '0;
    step(); step();
    check_reset_values("reset");
    rst = 1'b0;

    // Single miss on port 0, memory answers in the 7th BUSY cycle.
    rd_req0 = 1'b1; rd_addr0 = 32'hDEBA_D004;
    step();
    check("single_memreq", LW'(mem_rd_req), LW'(1'b1));
    check("single_addr",   LW'(mem_rd_addr), LW'(32'hDEBA_D000));
    check("single_gnt",    LW'(gnt), LW'(2'b01));
    repeat (6) step();
    check("single_wait_memreq", LW'(mem_rd_req), LW'(1'b1));
    check("single_wait_rv0",    LW'(ret_valid0), '0);
    mem_ret_valid = 1'b1; mem_ret_data = LINE_A;
    step();
    mem_ret_valid = 1'b0; mem_ret_data = '0;
    check("single_rv0",   LW'(ret_valid0), LW'(1'b1));
    check("single_data0", ret_data0, LINE_A);
    check("single_rv1",   LW'(ret_valid1), '0);
    check("single_no_timeout", LW'(timeout_err), '0);
    step();  // cache still holds rd_req0 for one more cycle
    check("single_rv0_pulse", LW'(ret_valid0), '0);
    check("single_idle",      LW'(state_dbg), LW'(ARB_IDLE));
    check("single_gnt_clr",   LW'(gnt), '0);
    rd_req0 = 1'b0;
    step();
    check("single_masked_no_regrant", LW'(mem_rd_req), '0);

    // Simultaneous misses after reset: port 0 first, port 1 back-to-back.
    do_reset();
    rd_req0 = 1'b1; rd_addr0 = 32'hA5A5_0011;
    rd_req1 = 1'b1; rd_addr1 = 32'h0000_1230;
    step();
    check("tie_gnt",  LW'(gnt), LW'(2'b01));
    check("tie_addr", LW'(mem_rd_addr), LW'(32'hA5A5_0010));
    step();
    mem_ret_valid = 1'b1; mem_ret_data = LINE_B;  // cycle M
    step();
    mem_ret_valid = 1'b0;
    check("tie_rv0", LW'(ret_valid0), LW'(1'b1));
    check("tie_rv1", LW'(ret_valid1), '0);
    rd_req0 = 1'b0;
    step();  // M+2
    check("tie_gap_memreq", LW'(mem_rd_req), '0);
    step();  // M+3
    check("tie_p1_memreq", LW'(mem_rd_req), LW'(1'b1));
    check("tie_p1_addr",   LW'(mem_rd_addr), LW'(32'h0000_1230));
    check("tie_p1_gnt",    LW'(gnt), LW'(2'b10));
    mem_ret_valid = 1'b1; mem_ret_data = LINE_A;
    step();
    mem_ret_valid = 1'b0;
    check("tie_p1_rv1",  LW'(ret_valid1), LW'(1'b1));
    check("tie_p1_data", ret_data1, LINE_A);
    check("tie_p1_rv0",  LW'(ret_valid0), '0);
    rd_req1 = 1'b0;
    step();

    // Fairness: both ports re-request continuously for six misses.
    rd_req0 = 1'b1; rd_req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("fair_gnt_%0d", i), LW'(gnt), (i % 2 == 0) ? LW'(2'b01) : LW'(2'b10));
      mem_ret_valid = 1'b1; mem_ret_data = LINE_B ^ LW'(i);
      step();
      mem_ret_valid = 1'b0;
      check($sformatf("fair_rv_%0d", i), LW'({ret_valid1, ret_valid0}),
            (i % 2 == 0) ? LW'(2'b01) : LW'(2'b10));
      check($sformatf("fair_data_%0d", i), ret_data0, LINE_B ^ LW'(i));
      step();
      check($sformatf("fair_idle_%0d", i), LW'(state_dbg), LW'(ARB_IDLE));
    end
    rd_req0 = 1'b0; rd_req1 = 1'b0;
    step();
    check("fair_quiet", LW'(mem_rd_req), '0);

    // Zero-wait memory: request in T, return in T+2.
    rd_req0 = 1'b1; rd_addr0 = 32'h1234_567F;
    step();
    check("zw_addr", LW'(mem_rd_addr), LW'(32'h1234_5670));
    mem_ret_valid = 1'b1; mem_ret_data = LINE_A;
    step();
    mem_ret_valid = 1'b0;
    rd_req0 = 1'b0;
    check("zw_rv0",   LW'(ret_valid0), LW'(1'b1));
    check("zw_data0", ret_data0, LINE_A);
    step();
    check("zw_rv0_off", LW'(ret_valid0), '0);
    mem_ret_valid = 1'b1; mem_ret_data = LINE_B;  // stray return while idle
    step();
    mem_ret_valid = 1'b0;
    check("stray_rv",     LW'({ret_valid1, ret_valid0}), '0);
    check("stray_memreq", LW'(mem_rd_req), '0);
    step();
    check("stray_rv_late", LW'({ret_valid1, ret_valid0}), '0);
    check("stray_line",    ret_data0, LINE_A);

    // Timeout: no return, flag rises after 8 BUSY cycles; then reset.
    rd_req1 = 1'b1; rd_addr1 = 32'h0BAD_F00D;
    step();  // BUSY cycle 1
    repeat (7) step();  // BUSY cycle 8
    check("to_before", LW'(timeout_err), '0);
    step();  // BUSY cycle 9
    check("to_set",    LW'(timeout_err), LW'(1'b1));
    check("to_memreq", LW'(mem_rd_req), LW'(1'b1));
    repeat (3) step();
    check("to_sticky", LW'(timeout_err), LW'(1'b1));
    check("to_busy",   LW'(state_dbg), LW'(ARB_BUSY));
    do_reset();
    rd_req1 = 1'b0;
    check_reset_values("midrst");
    mem_ret_valid = 1'b1; mem_ret_data = LINE_B;  // late memory return
    step();
    mem_ret_valid = 1'b0;
    check("late_rv",   LW'({ret_valid1, ret_valid0}), '0);
    check("late_line", ret_data0, '0);
    step();
    check("late_rv2",   LW'({ret_valid1, ret_valid0}), '0);
    check("late_state", LW'(state_dbg), LW'(ARB_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
